// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between ALU and LSU with starvation-bounded priority and tracks outstanding loads for hazard detection
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            aluValid,
  input  logic [4:0]      aluRd,
  input  logic [XLEN-1:0] aluData,
  output logic            aluReady,
  input  logic            lsuValid,
  input  logic [4:0]      lsuRd,
  input  logic [XLEN-1:0] lsuData,
  output logic            lsuReady,
  input  logic            setBusy,
  input  logic [4:0]      setBusySEL,
  input  logic [4:0]      readPort1SEL,
  input  logic [4:0]      readPort2SEL,
  output logic            hazard,
  output logic            WE,
  output logic [4:0]      writePortSEL,
  output logic [XLEN-1:0] writePort
);
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  logic [2:0] starve;
  logic [31:0] busy, busy_nxt;
  logic xfer;
  logic [4:0] win_rd;
  logic [XLEN-1:0] win_data;
  assign aluReady = !rst && aluValid && (!lsuValid || starve == SMAX);
  assign lsuReady = !rst && lsuValid && !aluReady;
  assign xfer = aluReady || lsuReady;
  assign win_rd = aluReady ? aluRd : lsuRd;
  assign win_data = aluReady ? aluData : lsuData;
  assign hazard = busy[readPort1SEL] | busy[readPort2SEL];
  always_comb begin
    busy_nxt = busy & ~(lsuReady ? 32'd1 << lsuRd : 32'd0);
    busy_nxt = busy_nxt | (setBusy ? 32'd1 << setBusySEL : 32'd0);
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      WE <= 1'b0;
      writePortSEL <= '0;
      writePort <= '0;
      starve <= '0;
      busy <= '0;
    end else begin
      WE <= xfer && win_rd != 5'd0;
      if (xfer) begin
        writePortSEL <= win_rd;
        writePort <= win_data;
      end
      starve <= aluReady ? 3'd0 : (aluValid && starve != SMAX) ? starve + 3'd1 : starve;
      busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic aluValid = 1'b0, lsuValid = 1'b0, setBusy = 1'b0;
  logic [4:0] aluRd = '0, lsuRd = '0, setBusySEL = '0, readPort1SEL = '0, readPort2SEL = '0;
  logic [31:0] aluData = '0, lsuData = '0;
  logic aluReady, lsuReady, hazard, WE;
  logic [4:0] writePortSEL;
  logic [31:0] writePort;
  int checks = 0;
  int errors = 0;
  regfile_wb_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluReady(aluReady),
    .lsuValid(lsuValid), .lsuRd(lsuRd), .lsuData(lsuData), .lsuReady(lsuReady),
    .setBusy(setBusy), .setBusySEL(setBusySEL),
    .readPort1SEL(readPort1SEL), .readPort2SEL(readPort2SEL), .hazard(hazard),
    .WE(WE), .writePortSEL(writePortSEL), .writePort(writePort)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; aluValid = 1'b1; aluRd = 5'd1; lsuValid = 1'b1; lsuRd = 5'd2;
    readPort1SEL = 5'd1; readPort2SEL = 5'd2;
    step(); step();
    chk("reset_we", 32'(WE), 32'd0);
    chk("reset_aluready", 32'(aluReady), 32'd0);
    chk("reset_lsuready", 32'(lsuReady), 32'd0);
    chk("reset_hazard", 32'(hazard), 32'd0);
    chk("reset_sel", 32'(writePortSEL), 32'd0);
    chk("reset_data", writePort, 32'd0);
    rst = 1'b0; aluValid = 1'b0; lsuValid = 1'b0;
  endtask
  task automatic test_alu_write();
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
    #1;
    chk("alu_ready", 32'(aluReady), 32'd1);
    chk("alu_lsuready", 32'(lsuReady), 32'd0);
    step();
    aluValid = 1'b0;
    chk("alu_we", 32'(WE), 32'd1);
    chk("alu_sel", 32'(writePortSEL), 32'd5);
    chk("alu_data", writePort, 32'hDEADBEEF);
    step();
    chk("alu_we_drop", 32'(WE), 32'd0);
    chk("alu_sel_hold", 32'(writePortSEL), 32'd5);
    chk("alu_data_hold", writePort, 32'hDEADBEEF);
  endtask
  task automatic test_x0();
    lsuValid = 1'b1; lsuRd = 5'd0; lsuData = 32'h1234;
    #1;
    chk("x0_lsuready", 32'(lsuReady), 32'd1);
    step();
    lsuValid = 1'b0;
    chk("x0_we", 32'(WE), 32'd0);
  endtask
  task automatic test_contention();
    aluValid = 1'b1; aluRd = 5'd3; aluData = 32'hAAAA0003;
    lsuValid = 1'b1; lsuRd = 5'd4; lsuData = 32'h55550004;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("cont_aluready", 32'(aluReady), (i % 4 == 3) ? 32'd1 : 32'd0);
      chk("cont_lsuready", 32'(lsuReady), (i % 4 == 3) ? 32'd0 : 32'd1);
      chk("cont_starve", 32'(dut.starve), 32'(i % 4));
      step();
      chk("cont_we", 32'(WE), 32'd1);
      chk("cont_sel", 32'(writePortSEL), (i % 4 == 3) ? 32'd3 : 32'd4);
      chk("cont_data", writePort, (i % 4 == 3) ? 32'hAAAA0003 : 32'h55550004);
    end
    chk("cont_starve_end", 32'(dut.starve), 32'd0);
    aluValid = 1'b0; lsuValid = 1'b0;
  endtask
  task automatic test_scoreboard();
    setBusy = 1'b1; setBusySEL = 5'd7; readPort1SEL = 5'd7; readPort2SEL = 5'd0;
    #1;
    chk("sb_hazard_before", 32'(hazard), 32'd0);
    step();
    setBusy = 1'b0;
    #1;
    chk("sb_hazard_set", 32'(hazard), 32'd1);
    lsuValid = 1'b1; lsuRd = 5'd7; lsuData = 32'h77;
    #1;
    chk("sb_lsuready", 32'(lsuReady), 32'd1);
    chk("sb_hazard_pending", 32'(hazard), 32'd1);
    step();
    lsuValid = 1'b0;
    #1;
    chk("sb_hazard_clear", 32'(hazard), 32'd0);
    chk("sb_we", 32'(WE), 32'd1);
    setBusy = 1'b1; setBusySEL = 5'd0; readPort1SEL = 5'd0; readPort2SEL = 5'd0;
    step();
    setBusy = 1'b0;
    #1;
    chk("sb_x0_hazard", 32'(hazard), 32'd0);
  endtask
  task automatic test_set_clear();
    setBusy = 1'b1; setBusySEL = 5'd9;
    step();
    lsuValid = 1'b1; lsuRd = 5'd9; lsuData = 32'h99;
    step();
    setBusy = 1'b0; lsuValid = 1'b0; readPort1SEL = 5'd9;
    #1;
    chk("sc_hazard", 32'(hazard), 32'd1);
    step();
    chk("sc_hazard_hold", 32'(hazard), 32'd1);
    rst = 1'b1; aluValid = 1'b1; aluRd = 5'd6; aluData = 32'h66;
    #1;
    chk("rstmid_aluready", 32'(aluReady), 32'd0);
    step();
    rst = 1'b0; aluValid = 1'b0;
    #1;
    chk("rstmid_hazard", 32'(hazard), 32'd0);
    chk("rstmid_we", 32'(WE), 32'd0);
    chk("rstmid_sel", 32'(writePortSEL), 32'd0);
  endtask
  initial begin
    test_reset();
    test_alu_write();
    test_x0();
    test_contention();
    test_scoreboard();
    test_set_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 `regfile`. It shares the register file's single write port (`WE`, `writePortSEL`, `writePort`) between the ALU write-back path and the load/store unit (LSU) path, using valid/ready handshakes with starvation-bounded priority. It also tracks registers with outstanding loads and flags read-after-write hazards for the issue stage. The block sits between the execute/memory stages and `regfile`.

## Interface
- `XLEN`, 32, data width of the write port.
- `STARVE_MAX`, 3, maximum consecutive cycles the ALU may lose arbitration while valid; range 1..7.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `aluValid` in 1: ALU result is pending.
- `aluRd` in 5: ALU destination register.
- `aluData` in XLEN: ALU result.
- `aluReady` out 1: ALU transfer accepted this cycle (combinational).
- `lsuValid` in 1: load data is pending.
- `lsuRd` in 5: load destination register.
- `lsuData` in XLEN: load data.
- `lsuReady` out 1: LSU transfer accepted this cycle (combinational).
- `setBusy` in 1: issue stage dispatched a load this cycle.
- `setBusySEL` in 5: destination register of that load.
- `readPort1SEL` in 5: rs1 of the instruction in issue.
- `readPort2SEL` in 5: rs2 of the instruction in issue.
- `hazard` out 1: rs1 or rs2 has an outstanding load (combinational).
- `WE` out 1: registered write enable to `regfile`.
- `writePortSEL` out 5: registered write address.
- `writePort` out XLEN: registered write data.

## Operation
- A transfer occurs on a requester when valid && ready at a rising edge. While valid && !ready, the requester holds Rd/Data stable.
- Grant rules (combinational, rst=0):
  - Only one requester valid: that requester is granted.
  - Both valid and `starve` < STARVE_MAX: LSU is granted.
  - Both valid and `starve` == STARVE_MAX: ALU is granted.
  - At most one ready is high per cycle. Both readies are 0 while rst=1.
- `starve` is a 3-bit counter:
  - +1 on each cycle with aluValid && !aluReady, saturating at STARVE_MAX.
  - Cleared on ALU transfer.
  - Holds otherwise.
- Write-port register:
  - On a granted transfer: `WE`=1 and `writePortSEL`/`writePort` take the winner's Rd/Data.
  - If the winner's Rd==0, the transfer is still accepted but `WE`=0 (x0 is never written).
  - With no transfer: `WE`=0, and `writePortSEL`/`writePort` hold their previous values.
- Scoreboard (`busy[31:1]`, `busy[0]` fixed at 0):
  - setBusy && setBusySEL!=0 sets busy[setBusySEL].
  - An LSU transfer clears busy[lsuRd].
  - If set and clear target the same register in one cycle, set wins.
  - ALU transfers do not affect busy.
- `hazard` = busy[readPort1SEL] | busy[readPort2SEL]. Selector 0 never causes a hazard.

## Timing
- Reset values, one edge with rst=1:
  - `WE`=0, `writePortSEL`=0, `writePort`=0.
  - All busy bits=0, `starve`=0.
- Reset mid-operation discards any pending grant and clears all busy bits. Requesters must re-present after reset.
- Latency: transfer at edge N → `WE`/`writePortSEL`/`writePort` valid from edge N until edge N+1, written into `regfile` at edge N+1.
- `hazard` changes combinationally with selectors and one cycle after setBusy/clear edges. A cleared register is hazard-free from the edge of the LSU transfer.
  - The issue stage must read the value no earlier than edge N+1. The regfile's same-cycle write/read behaviour is not relied on.
- Throughput: one write per cycle. With both requesters continuously valid, the ALU is granted exactly once every STARVE_MAX+1 cycles.

## Test plan
- Reset: assert rst for 2 cycles with both requesters valid → `WE`=0, both readies=0, `hazard`=0, `writePortSEL`=0.
- Single ALU write: aluValid=1, aluRd=5, aluData=32'hDEADBEEF for one cycle → aluReady=1 same cycle; next cycle `WE`=1, `writePortSEL`=5, `writePort`=32'hDEADBEEF; following cycle `WE`=0.
- x0 suppression: lsuValid=1, lsuRd=0, lsuData=32'h1234 → lsuReady=1, `WE` stays 0 next cycle.
- Contention, STARVE_MAX=3, both valid continuously with distinct Rd:
  - Grant sequence is LSU, LSU, LSU, ALU, repeating.
  - `starve` returns to 0 after each ALU grant.
  - ALU Rd/Data held stable throughout.
- Scoreboard: setBusy=1, setBusySEL=7, then readPort1SEL=7 → `hazard`=1 from next cycle. LSU transfer with lsuRd=7 → `hazard`=0 from the following cycle. readPort2SEL=0 never raises `hazard`.
- Simultaneous set/clear: busy[9]=1, LSU transfer lsuRd=9 in the same cycle as setBusy with setBusySEL=9 → busy[9] remains 1 and `hazard` on rs1=9 stays 1. Assert rst mid-sequence → busy cleared and `WE`=0 the next cycle.
